// File: rtl/prdecoder_pulse.sv
// Sequenced 3-to-8 decoder: buffers {en, code} entries in a small FIFO and replays
// each one as a registered one-hot (or all-zero) word held for PULSE_LEN cycles.
module prdecoder_pulse #(
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_code,
  input  logic                        in_en,
  output logic [7:0]                  out,
  output logic                        out_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    CNT_RELOAD = 8'(PULSE_LEN - 1);

  typedef enum logic {
    S_IDLE,
    S_DRIVE
  } state_e;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    out_q, out_d;
  logic          valid_q, valid_d;
  logic          push, pop;
  logic [3:0]    head;

  function automatic logic [7:0] decode(input logic [3:0] entry);
    return entry[3] ? (8'd1 << entry[2:0]) : 8'h00;
  endfunction

  // Ready depends only on stored occupancy, so a same-edge pop never frees a slot early.
  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign out        = out_q;
  assign out_valid  = valid_q;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_en, in_code};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        out_d   = '0;
        valid_d = 1'b0;
        if (count_q != '0) begin
          pop     = 1'b1;
          out_d   = decode(head);
          valid_d = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          out_d   = decode(head);
          valid_d = 1'b1;
          cnt_d   = CNT_RELOAD;
        end else begin
          out_d   = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        out_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_prdecoder_pulse.sv
// Directed bench for prdecoder_pulse: instance a uses PULSE_LEN=4, instance b PULSE_LEN=1.
module tb_prdecoder_pulse;

  logic       clk;
  logic       rst_n;

  logic       a_v, a_en, a_rdy, a_ov;
  logic [2:0] a_code, a_cnt;
  logic [7:0] a_out;

  logic       b_v, b_en, b_rdy, b_ov;
  logic [2:0] b_code, b_cnt;
  logic [7:0] b_out;

  int unsigned n_cmp;
  int unsigned n_err;

  // Hand-traced occupancy after each edge of the backpressure scenario.
  int unsigned bp_cnt [1:26] = '{1,1,2,3,4,3,4,4,4,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,0};

  prdecoder_pulse #(.PULSE_LEN(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_v), .in_ready(a_rdy), .in_code(a_code),
    .in_en(a_en), .out(a_out), .out_valid(a_ov), .fifo_count(a_cnt)
  );

  prdecoder_pulse #(.PULSE_LEN(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_v), .in_ready(b_rdy), .in_code(b_code),
    .in_en(b_en), .out(b_out), .out_valid(b_ov), .fifo_count(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          nxt;
    logic        acc;
    logic [7:0]  eo;
    logic        ev;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    a_v = 1'b0; a_en = 1'b0; a_code = '0;
    b_v = 1'b0; b_en = 1'b0; b_code = '0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_a_out", 32'(a_out), 32'h00);
      chk("rst_a_valid", 32'(a_ov), 32'h0);
      chk("rst_a_ready", 32'(a_rdy), 32'h1);
      chk("rst_a_count", 32'(a_cnt), 32'h0);
      chk("rst_b_count", 32'(b_cnt), 32'h0);
    end
    rst_n = 1'b1;

    // Idle after release.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_a_out", 32'(a_out), 32'h00);
      chk("idle_a_valid", 32'(a_ov), 32'h0);
      chk("idle_a_ready", 32'(a_rdy), 32'h1);
      chk("idle_a_count", 32'(a_cnt), 32'h0);
      chk("idle_b_out", 32'(b_out), 32'h00);
      chk("idle_b_ready", 32'(b_rdy), 32'h1);
    end

    // Single decode of code 5, held 4 cycles.
    a_v = 1'b1; a_code = 3'd5; a_en = 1'b1;
    step();
    a_v = 1'b0;
    chk("single_accept_out", 32'(a_out), 32'h00);
    chk("single_accept_valid", 32'(a_ov), 32'h0);
    chk("single_accept_count", 32'(a_cnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_out", 32'(a_out), 32'h20);
      chk("single_valid", 32'(a_ov), 32'h1);
      chk("single_count", 32'(a_cnt), 32'h0);
    end
    step();
    chk("single_end_out", 32'(a_out), 32'h00);
    chk("single_end_valid", 32'(a_ov), 32'h0);

    // PULSE_LEN=1: codes 0..7 back-to-back.
    b_v = 1'b1; b_code = 3'd0; b_en = 1'b1;
    step();
    chk("walk_first_out", 32'(b_out), 32'h00);
    chk("walk_first_count", 32'(b_cnt), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) b_code = 3'(i);
      else       b_v = 1'b0;
      step();
      eo = 8'h01 << (i - 1);
      chk("walk_out", 32'(b_out), 32'(eo));
      chk("walk_valid", 32'(b_ov), 32'h1);
      chk("walk_count", 32'(b_cnt), (i < 8) ? 32'h1 : 32'h0);
    end
    step();
    chk("walk_end_out", 32'(b_out), 32'h00);
    chk("walk_end_valid", 32'(b_ov), 32'h0);

    // Backpressure: in_valid held with codes 1..6, code advances only on accept.
    a_v = 1'b1; a_code = 3'd1; a_en = 1'b1; nxt = 1;
    for (int k = 1; k <= 26; k++) begin
      acc = a_v && a_rdy;
      step();
      if (acc) begin
        nxt++;
        if (nxt > 6) a_v = 1'b0;
        else         a_code = 3'(nxt);
      end
      ev = (k >= 2) && (k <= 25);
      eo = ev ? 8'(32'h1 << ((k - 2) / 4 + 1)) : 8'h00;
      chk("bp_out", 32'(a_out), 32'(eo));
      chk("bp_valid", 32'(a_ov), 32'(ev));
      chk("bp_count", 32'(a_cnt), bp_cnt[k]);
      chk("bp_ready", 32'(a_rdy), (bp_cnt[k] != 4) ? 32'h1 : 32'h0);
    end
    chk("bp_all_accepted", 32'(nxt), 32'd7);

    // in_en=0 between codes 3 and 6.
    for (int k = 1; k <= 14; k++) begin
      case (k)
        1:       begin a_v = 1'b1; a_code = 3'd3; a_en = 1'b1; end
        2:       begin a_v = 1'b1; a_code = 3'd7; a_en = 1'b0; end
        3:       begin a_v = 1'b1; a_code = 3'd6; a_en = 1'b1; end
        default: begin a_v = 1'b0; a_en = 1'b0; end
      endcase
      step();
      if (k >= 2 && k <= 5)        begin eo = 8'h08; ev = 1'b1; end
      else if (k >= 6 && k <= 9)   begin eo = 8'h00; ev = 1'b1; end
      else if (k >= 10 && k <= 13) begin eo = 8'h40; ev = 1'b1; end
      else                         begin eo = 8'h00; ev = 1'b0; end
      chk("en0_out", 32'(a_out), 32'(eo));
      chk("en0_valid", 32'(a_ov), 32'(ev));
    end

    // Reset mid-pulse with 3 codes buffered.
    a_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      a_v = 1'b1; a_code = 3'(k);
      step();
    end
    a_v = 1'b0;
    chk("midrst_pre_count", 32'(a_cnt), 32'h3);
    chk("midrst_pre_out", 32'(a_out), 32'h02);
    chk("midrst_pre_valid", 32'(a_ov), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(a_out), 32'h00);
    chk("midrst_valid", 32'(a_ov), 32'h0);
    chk("midrst_count", 32'(a_cnt), 32'h0);
    chk("midrst_ready", 32'(a_rdy), 32'h1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("postrst_out", 32'(a_out), 32'h00);
      chk("postrst_valid", 32'(a_ov), 32'h0);
      chk("postrst_count", 32'(a_cnt), 32'h0);
    end
    a_v = 1'b1; a_code = 3'd7; a_en = 1'b1;
    step();
    a_v = 1'b0;
    chk("postrst_push_count", 32'(a_cnt), 32'h1);
    step();
    chk("postrst_push_out", 32'(a_out), 32'h80);
    chk("postrst_push_valid", 32'(a_ov), 32'h1);
    chk("postrst_push_drain", 32'(a_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
